dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller used by the memory stage of the pipelined processor.
- The memory stage drives Rd/Wr requests into this block and holds the pipeline on Stall.
- On a miss the block runs an FSM that writes back the dirty victim and refills the line one word at a time over a handshaked main-memory port.
- DCacheReq and DCacheHit are the per-access pulses the processor bench counts.

---
 rtl/dcache_ctrl.sv | 176 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the memory stage.
// Misses write back a dirty victim and refill the line word by word over a handshaked memory port.
module dcache_ctrl #(
  parameter int INDEX_BITS = 5,
  parameter int WORDS      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        DCacheReq,
  output logic        DCacheHit,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  localparam int NLINES = 1 << INDEX_BITS;
  localparam int TAG_W  = 13 - INDEX_BITS;
  localparam int AW     = INDEX_BITS + 2;

  typedef enum logic [1:0] {IDLE, WB, FILL, FINISH} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    rst_q;
  logic [NLINES-1:0]       valid_q, dirty_q;
  logic [TAG_W-1:0]        tag_q  [NLINES];
  logic [15:0]             data_q [NLINES*WORDS];

  logic [TAG_W-1:0]        req_tag;
  logic [INDEX_BITS-1:0]   req_idx;
  logic [1:0]              req_word;
  logic                    req_any, req_legal, hit;
  logic [15:0]             rd_word, victim_word;

  logic                    arr_we;
  logic [AW-1:0]           arr_waddr;
  logic [15:0]             arr_wdata;
  logic                    set_dirty, fill_done;

  assign req_tag     = Addr[15:3+INDEX_BITS];
  assign req_idx     = Addr[2+INDEX_BITS:3];
  assign req_word    = Addr[2:1];
  assign req_any     = Rd | Wr;
  assign req_legal   = (Rd ^ Wr) & ~Addr[0];
  assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign rd_word     = data_q[{req_idx, req_word}];
  assign victim_word = data_q[{req_idx, cnt_q}];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    DataOut   = '0;
    Done      = 1'b0;
    Stall     = 1'b0;
    CacheHit  = 1'b0;
    DCacheReq = 1'b0;
    DCacheHit = 1'b0;
    err       = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    arr_we    = 1'b0;
    arr_waddr = {req_idx, req_word};
    arr_wdata = DataIn;
    set_dirty = 1'b0;
    fill_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The cycle right after a reset edge is blanked so every output reads 0.
        if (!rst_q) begin
          if (req_any && !req_legal) begin
            err  = 1'b1;
            Done = 1'b1;
          end else if (req_legal) begin
            DCacheReq = 1'b1;
            if (hit) begin
              Done      = 1'b1;
              CacheHit  = 1'b1;
              DCacheHit = 1'b1;
              if (Rd) begin
                DataOut = rd_word;
              end else begin
                arr_we    = 1'b1;
                set_dirty = 1'b1;
              end
            end else begin
              Stall   = 1'b1;
              cnt_d   = 2'd0;
              state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WB : FILL;
            end
          end
        end
      end

      WB: begin
        Stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[req_idx], req_idx, cnt_q, 1'b0};
        mem_wdata = victim_word;
        if (mem_ack) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = FILL;
        end
      end

      FILL: begin
        Stall     = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {req_tag, req_idx, cnt_q, 1'b0};
        arr_waddr = {req_idx, cnt_q};
        arr_wdata = mem_rdata;
        if (mem_ack) begin
          arr_we = 1'b1;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            fill_done = 1'b1;
            state_d   = FINISH;
          end
        end
      end

      FINISH: begin
        Done    = 1'b1;
        state_d = IDLE;
        if (Rd) begin
          DataOut = rd_word;
        end else if (Wr) begin
          arr_we    = 1'b1;
          set_dirty = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fill_done) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
      if (set_dirty) dirty_q[req_idx] <= 1'b1;
    end
  end

  // Line payload carries no reset; valid bits alone decide what is usable.
  always_ff @(posedge clk) begin
    if (arr_we)    data_q[arr_waddr] <= arr_wdata;
    if (fill_done) tag_q[req_idx]    <= req_tag;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl against a flat-memory reference plus a tag/valid/dirty directory.
module tb_dcache_ctrl;

  logic        clk, rst;
  logic [15:0] Addr, DataIn, DataOut, mem_addr, mem_wdata, mem_rdata;
  logic        Rd, Wr, Done, Stall, CacheHit, DCacheReq, DCacheHit, err;
  logic        mem_req, mem_we, mem_ack;

  dcache_ctrl #(.INDEX_BITS(5), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit),
    .DCacheReq(DCacheReq), .DCacheHit(DCacheHit), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] backing [32768];
  logic [15:0] gold    [32768];
  bit          m_valid [32];
  bit          m_dirty [32];
  logic [7:0]  m_tag   [32];

  int ack_mode = 0;
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rdata = backing[mem_addr[15:1]];

  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ack) backing[mem_addr[15:1]] <= mem_wdata;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    case (ack_mode)
      0:       mem_ack = 1'b1;
      1:       mem_ack = ((cyc % 3) == 2);
      default: mem_ack = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {8'h0, DataOut, Done, Stall, CacheHit, DCacheReq, DCacheHit, err,
            mem_req, mem_we, mem_addr, mem_wdata};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    for (int i = 0; i < 32768; i++) gold[i] = backing[i];
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after Done with inputs idle.
  task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input bit chk_lat);
    logic [4:0]  idx;
    logic [7:0]  t;
    logic [15:0] vbase, nbase, ea;
    bit          legal, hit, vdirty, done;
    logic [15:0] ex_addr [$];
    bit          ex_we   [$];
    logic [15:0] ex_data [$];
    int          k, nreq, ndreq, ndhit, nack, last_ack, stall_bad, exp_lat;

    idx    = a[7:3];
    t      = a[15:8];
    legal  = (rd != wr) && (a[0] == 1'b0);
    hit    = legal && m_valid[idx] && (m_tag[idx] == t);
    vdirty = legal && !hit && m_valid[idx] && m_dirty[idx];
    vbase  = 16'(int'(m_tag[idx]) * 256 + int'(idx) * 8);
    nbase  = a & 16'hFFF8;
    if (vdirty)
      for (int w = 0; w < 4; w++) begin
        ea = vbase + 16'(2 * w);
        ex_addr.push_back(ea); ex_we.push_back(1'b1); ex_data.push_back(gold[ea[15:1]]);
      end
    if (legal && !hit)
      for (int w = 0; w < 4; w++) begin
        ex_addr.push_back(nbase + 16'(2 * w)); ex_we.push_back(1'b0); ex_data.push_back(16'h0);
      end

    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    k = 0; nreq = 0; ndreq = 0; ndhit = 0; nack = 0; last_ack = 0; stall_bad = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (k == 0) chk("stall_c0", Stall, legal && !hit);
      ndreq += int'(DCacheReq);
      ndhit += int'(DCacheHit);
      if (mem_req) nreq++;
      if (mem_req && mem_ack) begin
        if (nack < ex_addr.size()) begin
          chk("mem_addr", mem_addr, ex_addr[nack]);
          chk("mem_we", mem_we, ex_we[nack]);
          if (ex_we[nack]) chk("mem_wdata", mem_wdata, ex_data[nack]);
        end
        nack++;
        last_ack = k;
      end
      if (Done) begin
        done = 1'b1;
        chk("stall_done", Stall, 0);
        chk("err", err, !legal);
        chk("cachehit", CacheHit, hit);
        if (rd && legal) chk("dataout", DataOut, gold[a[15:1]]);
      end else begin
        if (!Stall) stall_bad++;
        if (k >= 400) begin
          chk("timeout_done", Done, 1);
          break;
        end
        @(posedge clk); #1;
        k++;
      end
    end

    chk("dreq_pulses", ndreq, legal);
    chk("dhit_pulses", ndhit, hit);
    chk("stall_hold", stall_bad, 0);
    chk("ack_count", nack, ex_addr.size());
    if (legal && !hit) begin
      chk("req_contig", nreq, last_ack);
      chk("done_after_ack", k, last_ack + 1);
    end else begin
      chk("no_mem_req", nreq, 0);
    end
    if (chk_lat) begin
      exp_lat = (!legal || hit) ? 0 : (vdirty ? 9 : 5);
      chk("latency", k, exp_lat);
    end

    if (done && legal) begin
      if (!hit) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = t;
        m_dirty[idx] = 1'b0;
      end
      if (wr) begin
        gold[a[15:1]] = d;
        m_dirty[idx]  = 1'b1;
      end
    end

    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b0;
  endtask

  initial begin
    logic [15:0] a, d;
    bit          rd, wr;
    int          r;

    for (int i = 0; i < 32768; i++) begin
      backing[i] = 16'(i << 1);
      gold[i]    = 16'(i << 1);
    end
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 8'h0;
    end
    mem_ack = 1'b1;
    rst = 1'b1; Rd = 1'b1; Wr = 1'b1; Addr = 16'h0003; DataIn = 16'h0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", all_outs(), 64'h0);
    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b0; Addr = 16'h0;

    ack_mode = 0;
    access(1, 0, 16'h0010, 16'h0, 1);
    access(1, 0, 16'h0014, 16'h0, 1);
    access(0, 1, 16'h0012, 16'hBEEF, 1);
    access(1, 0, 16'h0012, 16'h0, 1);
    access(1, 0, 16'h0412, 16'h0, 1);

    ack_mode = 1;
    access(1, 0, 16'h0820, 16'h0, 0);

    ack_mode = 0;
    access(1, 1, 16'h0010, 16'h0, 1);
    access(1, 0, 16'h0003, 16'h0, 1);

    // Reset lands in the second FILL cycle of a clean miss.
    Rd = 1'b1; Wr = 1'b0; Addr = 16'h0030;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_abort_outs", all_outs(), 64'h0);
    model_reset();
    @(posedge clk); #1;
    access(1, 0, 16'h0030, 16'h0, 1);

    for (int n = 0; n < 300; n++) begin
      ack_mode = int'($urandom_range(0, 2));
      a  = 16'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 3) | ($urandom_range(0, 3) << 1));
      d  = 16'($urandom);
      r  = int'($urandom_range(0, 15));
      rd = r[0];
      wr = !r[0];
      if (r == 0) begin
        rd = 1'b1; wr = 1'b1;
      end else if (r == 1) begin
        a[0] = 1'b1;
      end
      access(rd, wr, a, d, ack_mode == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
